// File: rtl/hex_scroll_pkg.sv
// Shared types and constants for the hex_scroll_ctrl display sequencer.
package hex_scroll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // bit4 = blank, bits3:0 = hex digit
    typedef logic [4:0] char_t;

    localparam logic [6:0] BLANK_SEG  = 7'h7F;
    localparam char_t      BLANK_CODE = 5'h10;

    // Active-low glyphs (gfedcba), index 15 listed first
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// Character write port of hex_scroll_ctrl: valid/ready handshake.
interface hex_scroll_ctrl_if;
    logic                  wr_valid;
    hex_scroll_pkg::char_t wr_data;
    logic                  wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/seg7_decode.sv
// Combinational character code to active-low 7-segment pattern.
module seg7_decode
    import hex_scroll_pkg::*;
(
    input  char_t      code,
    output logic [6:0] seg_c
);
    always_comb begin
        seg_c = BLANK_SEG;
        if (!code[4]) seg_c = GLYPH[code[3:0]];
    end
endmodule

// File: rtl/hex_scroll_ctrl.sv
// Message buffer and right-to-left scroll sequencer for six 7-segment digits.
// Optional macro DEBOUNCE_EN: 2^16-cycle stability filter on each synchronised button.
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int unsigned MSG_MAX     = 16,
    parameter int unsigned TICK_BASE   = 5000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    hex_scroll_ctrl_if.slave         wr,
    input  logic [1:0]               btn_n,
    input  logic [3:0]               speed,
    output logic [6:0]               hex5,
    output logic [6:0]               hex4,
    output logic [6:0]               hex3,
    output logic [6:0]               hex2,
    output logic [6:0]               hex1,
    output logic [6:0]               hex0,
    output logic [1:0]               state_o,
    output logic [$clog2(MSG_MAX):0] msg_len
);
    localparam int unsigned LEN_W  = $clog2(MSG_MAX) + 1;
    localparam int unsigned PTR_W  = $clog2(MSG_MAX);
    localparam int unsigned TICK_W = $clog2(16 * TICK_BASE);
    localparam int unsigned DIGITS = 6;

    state_t                      state;
    logic [PTR_W-1:0]            pos;
    logic [TICK_W-1:0]           tick;
    logic [TICK_W-1:0]           period_m1;
    logic                        wr_ready_q;
    logic                        wr_fire;
    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [1:0]                  btn_lvl;
    logic [1:0]                  btn_prev;
    logic [1:0]                  press;
    logic                        run_p;
    logic                        clr_p;
    char_t                       msg_buf [MSG_MAX];
    char_t                       code    [DIGITS];
    logic [LEN_W-1:0]            idx     [DIGITS];
    logic [6:0]                  seg     [DIGITS];
    logic [6:0]                  hex_q   [DIGITS];

    // Button synchroniser and falling-edge detector
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_q   <= '1;
            btn_prev <= '1;
        end else begin
            sync_q[0] <= btn_n;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
            btn_prev <= btn_lvl;
        end
    end

`ifdef DEBOUNCE_EN
    logic [1:0][15:0] db_cnt;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            db_cnt  <= '0;
            btn_lvl <= '1;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sync_q[SYNC_STAGES-1][b] == btn_lvl[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == 16'hFFFF) begin
                    btn_lvl[b] <= sync_q[SYNC_STAGES-1][b];
                    db_cnt[b]  <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 16'd1;
                end
            end
        end
    end
`else
    assign btn_lvl = sync_q[SYNC_STAGES-1];
`endif

    assign press     = btn_prev & ~btn_lvl;
    assign run_p     = press[0];
    assign clr_p     = press[1];
    assign period_m1 = TICK_W'((32'(speed) + 32'd1) * TICK_BASE - 32'd1);
    assign wr_fire   = wr.wr_valid & wr_ready_q & ~clr_p;
    assign wr.wr_ready = wr_ready_q;

    // Control FSM, scroll timer and write counter; wr_ready tracks next state/length
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            msg_len    <= '0;
            pos        <= '0;
            tick       <= '0;
            wr_ready_q <= 1'b1;
        end else if (clr_p) begin
            state      <= IDLE;
            msg_len    <= '0;
            pos        <= '0;
            tick       <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tick <= '0;
                    pos  <= '0;
                    if (run_p && msg_len != '0) state <= RUN;
                    wr_ready_q <= !(run_p && msg_len != '0) &&
                                  (wr_fire ? (msg_len < LEN_W'(MSG_MAX - 1))
                                           : (msg_len < LEN_W'(MSG_MAX)));
                end
                RUN: begin
                    if (tick >= period_m1) begin
                        tick <= '0;
                        pos  <= (LEN_W'(pos) == msg_len - LEN_W'(1)) ? '0 : pos + PTR_W'(1);
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                    if (run_p) state <= PAUSE;
                    wr_ready_q <= 1'b0;
                end
                PAUSE: begin
                    if (run_p) state <= RUN;
                    wr_ready_q <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    tick       <= '0;
                    pos        <= '0;
                    wr_ready_q <= (msg_len < LEN_W'(MSG_MAX));
                end
            endcase
            if (wr_fire) msg_len <= msg_len + LEN_W'(1);
        end
    end

    // Message storage needs no reset: msg_len gates every read
    always_ff @(posedge clk_clk) begin
        if (wr_fire) msg_buf[msg_len[PTR_W-1:0]] <= wr.wr_data;
    end

    // Digit i shows buf[(pos+i) mod msg_len]; pos+i never exceeds msg_len+5
    always_comb begin
        for (int i = 0; i < int'(DIGITS); i++) begin
            idx[i] = LEN_W'(pos) + LEN_W'(i);
            for (int k = 0; k < int'(DIGITS); k++) begin
                if (msg_len != '0 && idx[i] >= msg_len) idx[i] = idx[i] - msg_len;
            end
            code[i] = (msg_len == '0) ? BLANK_CODE : msg_buf[idx[i][PTR_W-1:0]];
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        seg7_decode u_dec (
            .code  (code[g]),
            .seg_c (seg[g])
        );
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < int'(DIGITS); i++) hex_q[i] <= BLANK_SEG;
        end else begin
            for (int i = 0; i < int'(DIGITS); i++) hex_q[i] <= seg[i];
        end
    end

    assign hex5    = hex_q[0];
    assign hex4    = hex_q[1];
    assign hex3    = hex_q[2];
    assign hex2    = hex_q[3];
    assign hex1    = hex_q[4];
    assign hex0    = hex_q[5];
    assign state_o = state;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl against a cycle-level behavioural model.
module tb_hex_scroll_ctrl;
    localparam int MSG_MAX   = 8;
    localparam int TICK_BASE = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_n = 2'b11;
    logic [3:0] speed = 4'd0;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic [1:0] state_o;
    logic [3:0] msg_len;

    int n_checks = 0;
    int n_fail   = 0;

    hex_scroll_ctrl_if wr_if ();

    hex_scroll_ctrl #(
        .MSG_MAX     (MSG_MAX),
        .TICK_BASE   (TICK_BASE),
        .SYNC_STAGES (2)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .wr            (wr_if.slave),
        .btn_n         (btn_n),
        .speed         (speed),
        .hex5          (hex5),
        .hex4          (hex4),
        .hex3          (hex3),
        .hex2          (hex2),
        .hex1          (hex1),
        .hex0          (hex0),
        .state_o       (state_o),
        .msg_len       (msg_len)
    );

    always #5 clk = ~clk;

    // Reference glyphs, active-low gfedcba
    logic [6:0] tb_glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Behavioural model state
    int          m_state = 0;
    int          m_len   = 0;
    int          m_pos   = 0;
    int          m_tick  = 0;
    int          m_buf [MSG_MAX];
    logic [1:0]  hist [4] = '{2'b11, 2'b11, 2'b11, 2'b11};
    logic [41:0] exp_hex = {6{7'h7F}};
    logic        m_run, m_clr, m_fire;

    wire  [48:0] obs = {hex5, hex4, hex3, hex2, hex1, hex0, state_o, msg_len, wr_if.wr_ready};
    logic [48:0] exp_obs;
    assign exp_obs = {exp_hex, 2'(m_state), 4'(m_len), (m_state == 0 && m_len < MSG_MAX)};

    function automatic logic [6:0] seg_of(input int c);
        logic [6:0] r;
        r = (c >= 16) ? 7'h7F : tb_glyph[c];
        return r;
    endfunction

    // Press acts two synchroniser edges after it is sampled; display shows last cycle's model
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = 0; m_len = 0; m_pos = 0; m_tick = 0;
                for (int k = 0; k < 4; k++) hist[k] = 2'b11;
                exp_hex = {6{7'h7F}};
            end else begin
                hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = btn_n;
                m_run = !hist[2][0] && hist[3][0];
                m_clr = !hist[2][1] && hist[3][1];
                for (int i = 0; i < 6; i++)
                    exp_hex[41-7*i -: 7] = (m_len == 0) ? 7'h7F : seg_of(m_buf[(m_pos + i) % m_len]);
                m_fire = wr_if.wr_valid && m_state == 0 && m_len < MSG_MAX && !m_clr;
                if (m_clr) begin
                    m_state = 0; m_len = 0; m_pos = 0; m_tick = 0;
                end else begin
                    case (m_state)
                        0: begin
                            m_tick = 0; m_pos = 0;
                            if (m_run && m_len > 0) m_state = 1;
                        end
                        1: begin
                            if (m_tick + 1 >= (int'(speed) + 1) * TICK_BASE) begin
                                m_tick = 0;
                                m_pos  = (m_pos + 1) % m_len;
                            end else begin
                                m_tick++;
                            end
                            if (m_run) m_state = 2;
                        end
                        default: if (m_run) m_state = 1;
                    endcase
                    if (m_fire) begin
                        m_buf[m_len] = int'(wr_if.wr_data);
                        m_len++;
                    end
                end
            end
        end
    end

    task automatic write_char(input int d);
        int guard = 0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 5'(d);
        while (wr_if.wr_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout: wr_ready stayed %b, required 1", wr_if.wr_ready);
        end
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic press(input logic [1:0] mask);
        btn_n = ~mask;
        repeat (4) @(negedge clk);
        btn_n = 2'b11;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_n = 2'b11; speed = 4'd0;
        wr_if.wr_valid = 1'b0; wr_if.wr_data = 5'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {6{7'h7F}}) begin
            n_fail++; $display("FAIL reset_hex: got %h required %h", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h7F}});
        end
        n_checks++;
        if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", wr_if.wr_ready); end
        n_checks++;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", state_o); end
        n_checks++;
        if (msg_len !== 4'd0) begin n_fail++; $display("FAIL reset_len: got %0d required 0", msg_len); end
        n_checks++;
        if (obs !== exp_obs) begin n_fail++; $display("FAIL reset_model: got %h required %h", obs, exp_obs); end
    endtask

    task automatic test_write_fill();
        for (int d = 1; d <= 8; d++) begin
            write_char(d);
            if (d == 7) begin
                n_checks++;
                if (msg_len !== 4'd7) begin n_fail++; $display("FAIL fill_len7: got %0d required 7", msg_len); end
            end
        end
        n_checks++;
        if (msg_len !== 4'd8 || wr_if.wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got len %0d ready %b required len 8 ready 0", msg_len, wr_if.wr_ready);
        end
        wr_if.wr_valid = 1'b1; wr_if.wr_data = 5'd9;
        repeat (10) @(negedge clk);
        n_checks++;
        if (msg_len !== 4'd8) begin n_fail++; $display("FAIL fill_holdoff: got len %0d required 8", msg_len); end
        wr_if.wr_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
            n_fail++; $display("FAIL fill_display: got %h required glyphs 1..6", {hex5, hex4, hex3, hex2, hex1, hex0});
        end
        n_checks++;
        if (obs !== exp_obs) begin n_fail++; $display("FAIL fill_model: got %h required %h", obs, exp_obs); end
    endtask

    task automatic test_scroll();
        int g = 0;
        speed = 4'd0;
        press(2'b01);
        n_checks++;
        if (state_o !== 2'd1) begin n_fail++; $display("FAIL scroll_state: got %0d required 1", state_o); end
        while (hex5 === 7'h79 && g < 20) begin
            @(negedge clk); g++;
            n_checks++;
            if (obs !== exp_obs) begin n_fail++; $display("FAIL scroll_wait_model: got %h required %h", obs, exp_obs); end
        end
        n_checks++;
        if (hex5 !== 7'h24) begin n_fail++; $display("FAIL scroll_first_step: hex5 got %h required 24 (waited %0d)", hex5, g); end
        repeat (27) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) begin n_fail++; $display("FAIL scroll_model: got %h required %h", obs, exp_obs); end
        end
        n_checks++;
        if (hex5 !== 7'h00) begin n_fail++; $display("FAIL scroll_last: hex5 got %h required 00", hex5); end
        @(negedge clk);
        n_checks++;
        if (hex5 !== 7'h79) begin n_fail++; $display("FAIL scroll_wrap: hex5 got %h required 79", hex5); end
    endtask

    task automatic test_pause();
        press(2'b01);
        n_checks++;
        if (state_o !== 2'd2) begin n_fail++; $display("FAIL pause_state: got %0d required 2", state_o); end
        repeat (100) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) begin n_fail++; $display("FAIL pause_model: got %h required %h", obs, exp_obs); end
        end
        n_checks++;
        if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL pause_ready: got %b required 0", wr_if.wr_ready); end
        press(2'b01);
        repeat (40) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) begin n_fail++; $display("FAIL resume_model: got %h required %h", obs, exp_obs); end
        end
        n_checks++;
        if (state_o !== 2'd1) begin n_fail++; $display("FAIL resume_state: got %0d required 1", state_o); end
    endtask

    task automatic test_run_clear_same();
        press(2'b11);
        @(negedge clk);
        n_checks++;
        if (state_o !== 2'd0 || msg_len !== 4'd0 || {hex5, hex4, hex3, hex2, hex1, hex0} !== {6{7'h7F}}) begin
            n_fail++; $display("FAIL run_clear: got state %0d len %0d hex %h required 0 0 blank",
                               state_o, msg_len, {hex5, hex4, hex3, hex2, hex1, hex0});
        end
        n_checks++;
        if (obs !== exp_obs) begin n_fail++; $display("FAIL run_clear_model: got %h required %h", obs, exp_obs); end
    endtask

    task automatic test_run_with_write();
        btn_n = 2'b10;
        @(negedge clk);
        @(negedge clk);
        wr_if.wr_valid = 1'b1; wr_if.wr_data = 5'h03;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        btn_n = 2'b11;
        repeat (2) @(negedge clk);
        n_checks++;
        if (state_o !== 2'd0 || msg_len !== 4'd1) begin
            n_fail++; $display("FAIL run_write_ctrl: got state %0d len %0d required 0 1", state_o, msg_len);
        end
        n_checks++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {6{7'h30}}) begin
            n_fail++; $display("FAIL run_write_display: got %h required six 30", {hex5, hex4, hex3, hex2, hex1, hex0});
        end
        n_checks++;
        if (obs !== exp_obs) begin n_fail++; $display("FAIL run_write_model: got %h required %h", obs, exp_obs); end
    endtask

    task automatic test_random();
        logic prev_ready = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== exp_obs) begin n_fail++; $display("FAIL random_model cyc %0d: got %h required %h", c, obs, exp_obs); end
            if (!wr_if.wr_valid || prev_ready) begin
                wr_if.wr_valid = ($urandom_range(0, 2) == 0);
                wr_if.wr_data  = 5'($urandom_range(0, 31));
            end
            prev_ready = wr_if.wr_ready;
            if ($urandom_range(0, 14) == 0) btn_n[0] = ~btn_n[0];
            if ($urandom_range(0, 79) == 0) btn_n[1] = ~btn_n[1];
            if ($urandom_range(0, 99) == 0) speed = 4'($urandom_range(0, 3));
        end
        wr_if.wr_valid = 1'b0;
        btn_n = 2'b11;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_midreset();
        press(2'b10);
        write_char(4'hA);
        write_char(4'hB);
        write_char(4'hC);
        press(2'b01);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== {{6{7'h7F}}, 2'd0, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL midreset_values: got %h required %h", obs, {{6{7'h7F}}, 2'd0, 4'd0, 1'b1});
        end
        #2 rst_n = 1'b1;
        write_char(4'hE);
        @(negedge clk);
        n_checks++;
        if (obs !== exp_obs) begin n_fail++; $display("FAIL midreset_after: got %h required %h", obs, exp_obs); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 5'd0;
        test_reset();
        test_write_fill();
        test_scroll();
        test_pause();
        test_run_clear_same();
        test_run_with_write();
        test_random();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
